pea_pool: RTL

Parametrised projectile manager for the plant/zombie game. It replaces the single hard-wired pea (one X/Y pair) with a pool of NUM_PEAS independent projectile slots. The pool accepts fire requests from the plant logic, moves each live pea right once per frame, and retires peas when they leave the screen or strike the zombie hitbox. It reports hits to the zombie HP logic and sits between the plant/keyboard control and the sprite renderer.

---
 rtl/pea_pool.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pea_pool.sv
// pea_pool: pool of NUM_PEAS projectile slots with fire cooldown, rightward motion, off-screen retire and zombie hit counting
module pea_pool #(
   parameter int NUM_PEAS   = 4,
   parameter int W          = 10,
   parameter int SPEED      = 4,
   parameter int X_MAX      = 639,
   parameter int COOLDOWN   = 30,
   parameter int HIT_HALF_W = 16,
   parameter int HIT_HALF_H = 24
)(
   input  logic                          frame_clk,
   input  logic                          Reset,
   input  logic                          fire,
   input  logic                          PlantLive,
   input  logic [W-1:0]                  PlantX,
   input  logic [W-1:0]                  PlantY,
   input  logic                          ZomLive,
   input  logic [W-1:0]                  ZomCentralX,
   input  logic [W-1:0]                  ZomCentralY,
   output logic [NUM_PEAS-1:0]           PeaLive,
   output logic [NUM_PEAS*W-1:0]         PeaX,
   output logic [NUM_PEAS*W-1:0]         PeaY,
   output logic                          fired,
   output logic [$clog2(NUM_PEAS+1)-1:0] hit_count,
   output logic                          hit,
   output logic                          full
);
   localparam int HCW = $clog2(NUM_PEAS+1);
   localparam int CW  = $clog2(COOLDOWN+2);
   localparam logic [W:0]    SPD = SPEED[W:0];
   localparam logic [W:0]    XM  = X_MAX[W:0];
   localparam logic [W:0]    HHW = HIT_HALF_W[W:0];
   localparam logic [W:0]    HHH = HIT_HALF_H[W:0];
   localparam logic [CW-1:0] CDV = COOLDOWN[CW-1:0];

   typedef enum logic {IDLE, FLY} state_t;

   state_t         st_q [NUM_PEAS];
   state_t         st_d [NUM_PEAS];
   logic [W-1:0]   x_q  [NUM_PEAS];
   logic [W-1:0]   x_d  [NUM_PEAS];
   logic [W-1:0]   y_q  [NUM_PEAS];
   logic [W-1:0]   y_d  [NUM_PEAS];
   logic [CW-1:0]  cd_q, cd_d;
   logic [HCW-1:0] hc_q, hc_d;
   logic           fired_q, fired_d, hit_q, hit_d, full_q, full_d;
   logic           free, accept, placed;
   logic [W:0]     nx, dx, dy;

   // next-state: per-slot hit/retire/move, lowest idle slot takes an accepted fire, cooldown countdown
   always_comb begin
      free = 1'b0;
      for (int i = 0; i < NUM_PEAS; i++) free = free | (st_q[i] == IDLE);
      accept = fire & PlantLive & (cd_q == '0) & free;
      cd_d = accept ? CDV : (cd_q != '0 ? cd_q - 1'b1 : cd_q);
      hc_d = '0;
      placed = 1'b0;
      full_d = 1'b1;
      nx = '0;
      dx = '0;
      dy = '0;
      for (int i = 0; i < NUM_PEAS; i++) begin
         st_d[i] = st_q[i];
         x_d[i] = x_q[i];
         y_d[i] = y_q[i];
         nx = {1'b0, x_q[i]} + SPD;
         dx = x_q[i] > ZomCentralX ? {1'b0, x_q[i] - ZomCentralX} : {1'b0, ZomCentralX - x_q[i]};
         dy = y_q[i] > ZomCentralY ? {1'b0, y_q[i] - ZomCentralY} : {1'b0, ZomCentralY - y_q[i]};
         if (st_q[i] == FLY) begin
            if (ZomLive && dx <= HHW && dy <= HHH) begin
               st_d[i] = IDLE;
               hc_d = hc_d + 1'b1;
            end else if (nx > XM) begin
               st_d[i] = IDLE;
            end else begin
               x_d[i] = nx[W-1:0];
            end
         end else if (accept && !placed) begin
            placed = 1'b1;
            st_d[i] = FLY;
            x_d[i] = PlantX;
            y_d[i] = PlantY;
         end
         full_d = full_d & (st_d[i] == FLY);
      end
      fired_d = accept;
      hit_d = hc_d != '0;
   end

   // state registers with asynchronous active-low clear
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         st_q    <= '{default: IDLE};
         x_q     <= '{default: '0};
         y_q     <= '{default: '0};
         cd_q    <= '0;
         hc_q    <= '0;
         fired_q <= 1'b0;
         hit_q   <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         st_q    <= st_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cd_q    <= cd_d;
         hc_q    <= hc_d;
         fired_q <= fired_d;
         hit_q   <= hit_d;
         full_q  <= full_d;
      end
   end

   for (genvar g = 0; g < NUM_PEAS; g++) begin : g_out
      assign PeaLive[g]       = st_q[g] == FLY;
      assign PeaX[g*W +: W]   = x_q[g];
      assign PeaY[g*W +: W]   = y_q[g];
   end

   assign fired     = fired_q;
   assign hit_count = hc_q;
   assign hit       = hit_q;
   assign full      = full_q;
endmodule
